// File: rtl/ring_pe_eject.sv
// ring_pe_eject
// -----------------------------------------------------------------------------
// Ejection-side port of a gold-ring router node. Packets already routed to this
// node arrive on the clockwise (cw) and counter-clockwise (ccw) channels and are
// handed to the local processing element (PE). One packet is held per virtual
// channel (VC). The ring-wide polarity signal interleaves the two VCs: in each
// cycle VC[polarity] may be written and VC[~polarity] may be read.
//
// Packet format: [63] VC, [62] direction, [61:56] reserved, [55:48] hop,
//                [47:0] payload.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high
//   polarity   in   1   ring phase, toggles every cycle
//   cwsi       in   1   cw channel has a packet for this node
//   cwdi       in  64   cw packet
//   cwri       out  1   cw packet accepted this cycle
//   ccwsi      in   1   ccw channel has a packet for this node
//   ccwdi      in  64   ccw packet
//   ccwri      out  1   ccw packet accepted this cycle
//   peso       out  1   packet valid to PE
//   pedo       out 64   packet to PE (zero when peso=0)
//   pero       in   1   PE ready
//   err_hop    out  1   one-cycle pulse: non-zero-hop packet dropped
//   eject_cnt  out 16   packets delivered to PE, wraps
//
// Build option:
//   EJECT_HOP_CHECK_EN  when defined, a granted packet with non-zero hop is
//                       accepted but dropped and flagged on err_hop. When
//                       undefined every granted packet is stored and err_hop
//                       is tied low.
// -----------------------------------------------------------------------------
module ring_pe_eject (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        cwsi,
  input  logic [63:0] cwdi,
  output logic        cwri,
  input  logic        ccwsi,
  input  logic [63:0] ccwdi,
  output logic        ccwri,
  output logic        peso,
  output logic [63:0] pedo,
  input  logic        pero,
  output logic        err_hop,
  output logic [15:0] eject_cnt
);

  logic [1:0][63:0] pkt_buf_r;
  logic [1:0]       full_r;
  logic             rr_r;
  logic [15:0]      eject_cnt_r;

  logic             wr_idx_s;
  logic             rd_idx_s;
  logic             cw_elig_s;
  logic             ccw_elig_s;
  logic             contend_s;
  logic             cw_gnt_s;
  logic             ccw_gnt_s;
  logic             any_gnt_s;
  logic [63:0]      win_pkt_s;
  logic             store_s;
  logic             peso_s;
  logic [63:0]      pedo_s;
  logic             xfer_s;

  // Phase indices: write entry follows polarity, read entry is the other one,
  // so a single entry is never written and read in the same cycle.
  assign wr_idx_s = polarity;
  assign rd_idx_s = ~polarity;

  // Eligibility and round-robin grant; the only combinational input-to-output path.
  always_comb begin
    cw_elig_s  = 1'b0;
    ccw_elig_s = 1'b0;
    cw_gnt_s   = 1'b0;
    ccw_gnt_s  = 1'b0;
    if (reset) begin
      cw_elig_s  = 1'b0;
      ccw_elig_s = 1'b0;
    end else begin
      // A packet whose VC bit disagrees with the phase is never accepted.
      cw_elig_s  = cwsi  & (cwdi[63]  == polarity) & ~full_r[wr_idx_s];
      ccw_elig_s = ccwsi & (ccwdi[63] == polarity) & ~full_r[wr_idx_s];
    end
    // rr_r = 0 favours cw, rr_r = 1 favours ccw; it only matters under contention.
    cw_gnt_s  = cw_elig_s  & (~ccw_elig_s | ~rr_r);
    ccw_gnt_s = ccw_elig_s & (~cw_elig_s  |  rr_r);
  end

  assign contend_s = cw_elig_s & ccw_elig_s;
  assign any_gnt_s = cw_gnt_s | ccw_gnt_s;
  assign win_pkt_s = ccw_gnt_s ? ccwdi : cwdi;
  assign cwri      = cw_gnt_s;
  assign ccwri     = ccw_gnt_s;

`ifdef EJECT_HOP_CHECK_EN
  logic hop_bad_s;
  logic err_hop_r;

  assign hop_bad_s = any_gnt_s & (win_pkt_s[55:48] != 8'h00);
  assign store_s   = any_gnt_s & ~hop_bad_s;

  // One-cycle error pulse for a packet dropped because its hop count is non-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_hop_r <= 1'b0;
    end else begin
      err_hop_r <= hop_bad_s;
    end
  end

  assign err_hop = err_hop_r;
`else
  assign store_s = any_gnt_s;
  assign err_hop = 1'b0;
`endif

  // PE-side view of the entry whose read phase is current.
  always_comb begin
    peso_s = full_r[rd_idx_s];
    pedo_s = 64'h0000_0000_0000_0000;
    if (peso_s) begin
      pedo_s = pkt_buf_r[rd_idx_s];
    end else begin
      pedo_s = 64'h0000_0000_0000_0000;
    end
  end

  assign xfer_s = peso_s & pero;
  assign peso   = peso_s;
  assign pedo   = pedo_s;

  // Packet storage and occupancy: set on accept, clear on PE transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_buf_r[0] <= 64'h0000_0000_0000_0000;
      pkt_buf_r[1] <= 64'h0000_0000_0000_0000;
      full_r       <= 2'b00;
    end else begin
      if (store_s) begin
        pkt_buf_r[wr_idx_s] <= win_pkt_s;
        full_r[wr_idx_s]    <= 1'b1;
      end
      if (xfer_s) begin
        full_r[rd_idx_s] <= 1'b0;
      end
    end
  end

  // Round-robin pointer: after a contended grant, favour the side that lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_r <= 1'b0;
    end else if (contend_s) begin
      rr_r <= ~rr_r;
    end
  end

  // Delivered-packet counter, free-running wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      eject_cnt_r <= 16'h0000;
    end else if (xfer_s) begin
      eject_cnt_r <= eject_cnt_r + 16'h0001;
    end
  end

  assign eject_cnt = eject_cnt_r;

endmodule

// File: tb/tb_ring_pe_eject.sv
// tb_ring_pe_eject
// -----------------------------------------------------------------------------
// Self-checking bench for ring_pe_eject. Each cycle the bench drives inputs,
// predicts every output from a small behavioural model of the ejection port
// (two VC slots, a preference bit and a delivery count), compares on the
// falling edge, then advances the model at the rising edge. Directed scenarios
// cover single delivery, contention, backpressure, phase violation, hop check,
// mid-run reset and the 16-bit counter wrap; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_ring_pe_eject;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        cwsi;
  logic [63:0] cwdi;
  logic        cwri;
  logic        ccwsi;
  logic [63:0] ccwdi;
  logic        ccwri;
  logic        peso;
  logic [63:0] pedo;
  logic        pero;
  logic        err_hop;
  logic [15:0] eject_cnt;

  ring_pe_eject dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .cwsi      (cwsi),
    .cwdi      (cwdi),
    .cwri      (cwri),
    .ccwsi     (ccwsi),
    .ccwdi     (ccwdi),
    .ccwri     (ccwri),
    .peso      (peso),
    .pedo      (pedo),
    .pero      (pero),
    .err_hop   (err_hop),
    .eject_cnt (eject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the port
  logic [63:0] slot_pkt [2];
  bit          slot_busy [2];
  bit          prefer_ccw;
  int unsigned delivered;
  bit          hop_flag;

  // Values sampled on the last check, for directed scenarios
  logic        obs_cwri, obs_ccwri, obs_peso, obs_err_hop;
  logic [63:0] obs_pedo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    slot_busy[0] = 1'b0;
    slot_busy[1] = 1'b0;
    prefer_ccw   = 1'b0;
    delivered    = 0;
    hop_flag     = 1'b0;
  endtask

  // One clock cycle with the currently driven inputs: predict, compare, advance.
  task automatic step();
    bit          wr, rd, cw_ok, ccw_ok, take_cw, take_ccw, offer;
    logic [63:0] got_pkt, want_pedo;
    wr       = polarity;
    rd       = !polarity;
    cw_ok    = !reset && cwsi  && (cwdi[63]  == wr) && !slot_busy[wr];
    ccw_ok   = !reset && ccwsi && (ccwdi[63] == wr) && !slot_busy[wr];
    take_cw  = cw_ok  && (!ccw_ok || !prefer_ccw);
    take_ccw = ccw_ok && (!cw_ok  ||  prefer_ccw);
    offer    = slot_busy[rd];
    want_pedo = offer ? slot_pkt[rd] : 64'h0;
    #4;
    obs_cwri = cwri; obs_ccwri = ccwri; obs_peso = peso; obs_pedo = pedo; obs_err_hop = err_hop;
    check_eq("cwri",      cwri,      take_cw);
    check_eq("ccwri",     ccwri,     take_ccw);
    check_eq("peso",      peso,      offer);
    check_eq("pedo",      pedo,      want_pedo);
    check_eq("err_hop",   err_hop,   hop_flag);
    check_eq("eject_cnt", eject_cnt, 64'(delivered % 65536));
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      got_pkt  = take_ccw ? ccwdi : cwdi;
      hop_flag = 1'b0;
      if (take_cw || take_ccw) begin
`ifdef EJECT_HOP_CHECK_EN
        if (got_pkt[55:48] != 8'h00) hop_flag = 1'b1;
        else begin slot_pkt[wr] = got_pkt; slot_busy[wr] = 1'b1; end
`else
        slot_pkt[wr] = got_pkt; slot_busy[wr] = 1'b1;
`endif
      end
      if (offer && pero) begin
        slot_busy[rd] = 1'b0;
        delivered++;
      end
      if (cw_ok && ccw_ok) prefer_ccw = !prefer_ccw;
    end
    #1;
  endtask

  task automatic idle_inputs();
    cwsi = 1'b0; ccwsi = 1'b0; cwdi = 64'h0; ccwdi = 64'h0; pero = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    polarity = 1'b0; step();
    polarity = 1'b1; step();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] rand_pkt(input logic pol);
    logic [63:0] p;
    p = {$urandom(), $urandom()};
    p[63] = ($urandom_range(3) == 0) ? ~pol : pol;
    p[55:48] = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
    return p;
  endfunction

  initial begin
    logic [15:0] cnt0;
    model_reset();
    idle_inputs();
    reset = 1'b1;
    polarity = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    polarity = 1'b0; step();
    check_eq("rst_peso", obs_peso, 1'b0);
    check_eq("rst_cnt",  eject_cnt, 16'h0000);

    // Single delivery
    do_reset();
    polarity = 1'b0; cwsi = 1'b1; cwdi = 64'h0000_0000_0000_0001; pero = 1'b1; step();
    check_eq("sd_cwri", obs_cwri, 1'b1);
    polarity = 1'b1; cwsi = 1'b0; step();
    check_eq("sd_peso", obs_peso, 1'b1);
    check_eq("sd_pedo", obs_pedo, 64'h0000_0000_0000_0001);
    check_eq("sd_cnt",  eject_cnt, 16'h0001);

    // Contention on VC1: cw first, ccw two cycles later
    do_reset();
    cwsi = 1'b1; ccwsi = 1'b1; pero = 1'b1;
    cwdi = 64'h8000_0000_0000_0003; ccwdi = 64'h8000_0000_0000_0007;
    polarity = 1'b1; step();
    check_eq("ct_cw1",  obs_cwri,  1'b1);
    check_eq("ct_ccw1", obs_ccwri, 1'b0);
    polarity = 1'b0; step();
    check_eq("ct_pedo1", obs_pedo, 64'h8000_0000_0000_0003);
    polarity = 1'b1; step();
    check_eq("ct_cw2",  obs_cwri,  1'b0);
    check_eq("ct_ccw2", obs_ccwri, 1'b1);
    ccwsi = 1'b0; cwsi = 1'b0;
    polarity = 1'b0; step();
    check_eq("ct_pedo2", obs_pedo, 64'h8000_0000_0000_0007);

    // Backpressure on VC0
    do_reset();
    polarity = 1'b0; cwsi = 1'b1; cwdi = 64'h0000_0000_0000_00A5; pero = 1'b0; step();
    check_eq("bp_acc", obs_cwri, 1'b1);
    cnt0 = eject_cnt;
    for (int i = 0; i < 6; i++) begin
      polarity = (i % 2 == 0); step();
      check_eq("bp_cwri", obs_cwri, 1'b0);
      check_eq("bp_peso", obs_peso, (i % 2 == 0));
    end
    cwsi = 1'b0; pero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      polarity = (i % 2 == 0); step();
    end
    check_eq("bp_once", eject_cnt - cnt0, 16'h0001);

    // Phase violation
    do_reset();
    polarity = 1'b0; cwsi = 1'b1; cwdi = 64'h8000_0000_0000_0042; pero = 1'b1; step();
    check_eq("pv_cwri", obs_cwri, 1'b0);
    cwsi = 1'b0; polarity = 1'b1; step();
    check_eq("pv_peso", obs_peso, 1'b0);

`ifdef EJECT_HOP_CHECK_EN
    // Hop check: accepted, dropped, flagged
    do_reset();
    cnt0 = eject_cnt;
    polarity = 1'b0; cwsi = 1'b1; cwdi = 64'h0002_0000_0000_0055; pero = 1'b1; step();
    check_eq("hop_cwri", obs_cwri, 1'b1);
    cwsi = 1'b0; polarity = 1'b1; step();
    check_eq("hop_err",  obs_err_hop, 1'b1);
    check_eq("hop_peso", obs_peso, 1'b0);
    check_eq("hop_cnt",  eject_cnt, cnt0);
`endif

    // Mid-run reset with both entries full
    do_reset();
    pero = 1'b0; cwsi = 1'b1;
    polarity = 1'b0; cwdi = 64'h0000_0000_0000_0011; step();
    polarity = 1'b1; cwdi = 64'h8000_0000_0000_0022; step();
    cwsi = 1'b0; reset = 1'b1; polarity = 1'b0; step();
    reset = 1'b0; polarity = 1'b1; step();
    check_eq("mr_peso1", obs_peso, 1'b0);
    polarity = 1'b0; step();
    check_eq("mr_peso0", obs_peso, 1'b0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      polarity = i[0];
      reset = ($urandom_range(199) == 0);
      cwsi  = $urandom_range(1);
      ccwsi = $urandom_range(1);
      cwdi  = rand_pkt(polarity);
      ccwdi = rand_pkt(polarity);
      pero  = ($urandom_range(3) != 0);
      step();
    end
    reset = 1'b0;

    // Counter wrap: exactly 65536 deliveries
    do_reset();
    pero = 1'b1; cwsi = 1'b1; ccwsi = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      polarity = i[0];
      cwdi = {polarity, 15'h0000, 48'(i)};
      step();
    end
    cwsi = 1'b0;
    polarity = 1'b0; step();
    polarity = 1'b1; step();
    check_eq("wrap_cnt", eject_cnt, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
